// File: rtl/cordic_iter_if.sv
// cordic_iter_if: upstream sample handshake, downstream result handshake and status for cordic_iter.
interface cordic_iter_if;
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic signed [17:0] x_in;
  logic signed [17:0] y_in;
  logic signed [15:0] z_in;
  logic        [1:0]  d_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] x_out;
  logic signed [17:0] y_out;
  logic signed [15:0] z_out;
  logic               busy;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, d_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, d_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );
endinterface

// File: rtl/cordic_iter.sv
// cordic_iter: iterative shift-add CORDIC (rotation/vector mode) on one shared datapath.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle GAIN state that scales x/y back to unity gain.
module cordic_iter #(
  parameter int ITER = 16
) (
  input  logic          clk,
  input  logic          rst,
  cordic_iter_if.slave  io
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
    GAIN = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t             state;
  logic        [3:0]  i;
  logic               mode_r;
  logic        [1:0]  d_r;
  logic signed [17:0] xr, yr, xs, ys, xn, yn;
  logic signed [15:0] zr, zn, at;
  logic               s_pos;
  logic               neg;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 16'sd8192;
      4'd1:    atan_lut = 16'sd4836;
      4'd2:    atan_lut = 16'sd2555;
      4'd3:    atan_lut = 16'sd1297;
      4'd4:    atan_lut = 16'sd651;
      4'd5:    atan_lut = 16'sd326;
      4'd6:    atan_lut = 16'sd163;
      4'd7:    atan_lut = 16'sd81;
      4'd8:    atan_lut = 16'sd41;
      4'd9:    atan_lut = 16'sd20;
      4'd10:   atan_lut = 16'sd10;
      4'd11:   atan_lut = 16'sd5;
      4'd12:   atan_lut = 16'sd3;
      4'd13:   atan_lut = 16'sd1;
      4'd14:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  // s = +1 drives z toward 0 in rotation mode and y toward 0 in vector mode
  assign s_pos = mode_r ? yr[17] : ~zr[15];
  assign xs    = xr >>> i;
  assign ys    = yr >>> i;
  assign at    = atan_lut(i);
  assign xn    = s_pos ? xr - ys : xr + ys;
  assign yn    = s_pos ? yr + xs : yr - xs;
  assign zn    = s_pos ? zr - at : zr + at;
  assign neg   = ~mode_r && (d_r == 2'b11);

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [34:0] GAIN_K = 35'sd19898;
  localparam logic signed [34:0] ROUND  = 35'sd16384;
  logic signed [34:0] xp, yp;
  logic signed [17:0] xg, yg;

  assign xp = {{17{xr[17]}}, xr} * GAIN_K + ROUND;
  assign yp = {{17{yr[17]}}, yr} * GAIN_K + ROUND;
  assign xg = 18'(xp >>> 15);
  assign yg = 18'(yp >>> 15);
`endif

  assign io.in_ready = (state == IDLE) && !rst;
  assign io.busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      mode_r       <= 1'b0;
      d_r          <= '0;
      xr           <= '0;
      yr           <= '0;
      zr           <= '0;
      io.out_valid <= 1'b0;
      io.x_out     <= '0;
      io.y_out     <= '0;
      io.z_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            xr     <= io.x_in;
            yr     <= io.y_in;
            zr     <= io.z_in;
            mode_r <= io.mode;
            d_r    <= io.d_in;
            i      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          xr <= xn;
          yr <= yn;
          zr <= zn;
          i  <= i + 4'd1;
          if (i == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= GAIN;
`else
            // Final micro-rotation result goes straight to the output with the quadrant fix applied
            io.x_out     <= neg ? -xn : xn;
            io.y_out     <= neg ? -yn : yn;
            io.z_out     <= zn;
            io.out_valid <= 1'b1;
            state        <= DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          io.x_out     <= neg ? -xg : xg;
          io.y_out     <= neg ? -yg : yg;
          io.z_out     <= zr;
          io.out_valid <= 1'b1;
          state        <= DONE;
        end
`endif
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed self-checking bench for cordic_iter (ITER=16 and ITER=1 instances).
module tb_cordic_iter;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT16  = 17;
  localparam int LAT1   = 2;
  localparam int ROT45  = 7071;
  localparam int ROTNEG = -10000;
  localparam int VMAG   = 14142;
  localparam int IT1_XY = 607;
`else
  localparam int LAT16  = 16;
  localparam int LAT1   = 1;
  localparam int ROT45  = 11645;
  localparam int ROTNEG = -16468;
  localparam int VMAG   = 23290;
  localparam int IT1_XY = 1000;
`endif

  cordic_iter_if io ();
  cordic_iter_if io1 ();

  cordic_iter #(.ITER(16)) u_dut (.clk(clk), .rst(rst), .io(io));
  cordic_iter #(.ITER(1))  u_dut1 (.clk(clk), .rst(rst), .io(io1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send(input logic m, input int x, input int y, input int z,
                      input logic [1:0] d, output int lat, output bit got);
    int w;
    @(negedge clk);
    io.mode     = m;
    io.x_in     = 18'(x);
    io.y_in     = 18'(y);
    io.z_in     = 16'(z);
    io.d_in     = d;
    io.in_valid = 1'b1;
    w = 0;
    while (!io.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = io.out_valid;
    end
  endtask

  task automatic release_result();
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (io.in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", io.in_ready);
    end
    checks++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got out_valid=%b busy=%b expected 0/0", io.out_valid, io.busy);
    end
    checks++;
    if (io.x_out !== 18'sd0 || io.y_out !== 18'sd0 || io.z_out !== 16'sd0) begin
      fails++; $display("[TB] FAIL reset_outputs: got %0d/%0d/%0d expected 0/0/0", io.x_out, io.y_out, io.z_out);
    end
    checks++;
    if (io1.out_valid !== 1'b0 || io1.in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_iter1: got out_valid=%b in_ready=%b expected 0/0", io1.out_valid, io1.in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (io.in_ready !== 1'b1 || io.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL post_reset_idle: got in_ready=%b busy=%b expected 1/0", io.in_ready, io.busy);
    end
  endtask

  task automatic test_rotation();
    int lat; bit got;
    send(1'b0, 10000, 0, 8192, 2'b01, lat, got);
    checks++;
    if (!got || lat != LAT16) begin
      fails++; $display("[TB] FAIL rot_latency: got %0d (valid=%b) expected %0d", lat, got, LAT16);
    end
    checks++;
    if (io.x_out < ROT45 - 4 || io.x_out > ROT45 + 4) begin
      fails++; $display("[TB] FAIL rot_x: got %0d expected %0d+-4", io.x_out, ROT45);
    end
    checks++;
    if (io.y_out < ROT45 - 4 || io.y_out > ROT45 + 4) begin
      fails++; $display("[TB] FAIL rot_y: got %0d expected %0d+-4", io.y_out, ROT45);
    end
    checks++;
    if (io.z_out < -2 || io.z_out > 2) begin
      fails++; $display("[TB] FAIL rot_z: got %0d expected 0+-2", io.z_out);
    end
    checks++;
    if (io.busy !== 1'b1 || io.in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL done_flags: got busy=%b in_ready=%b expected 1/0", io.busy, io.in_ready);
    end
    release_result();
    checks++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL rot_release: got out_valid=%b busy=%b expected 0/0", io.out_valid, io.busy);
    end
  endtask

  task automatic test_rotation_neg();
    int lat; bit got;
    send(1'b0, 10000, 0, 0, 2'b11, lat, got);
    checks++;
    if (!got || lat != LAT16) begin
      fails++; $display("[TB] FAIL neg_latency: got %0d (valid=%b) expected %0d", lat, got, LAT16);
    end
    checks++;
    if (io.x_out < ROTNEG - 4 || io.x_out > ROTNEG + 4) begin
      fails++; $display("[TB] FAIL neg_x: got %0d expected %0d+-4", io.x_out, ROTNEG);
    end
    checks++;
    if (io.y_out < -4 || io.y_out > 4) begin
      fails++; $display("[TB] FAIL neg_y: got %0d expected 0+-4", io.y_out);
    end
    release_result();
  endtask

  task automatic test_vector();
    int lat; bit got;
    for (int r = 0; r < 2; r++) begin
      send(1'b1, 10000, 10000, 0, (r == 0) ? 2'b00 : 2'b11, lat, got);
      checks++;
      if (!got || lat != LAT16) begin
        fails++; $display("[TB] FAIL vec_latency[%0d]: got %0d (valid=%b) expected %0d", r, lat, got, LAT16);
      end
      checks++;
      if (io.x_out < VMAG - 6 || io.x_out > VMAG + 6) begin
        fails++; $display("[TB] FAIL vec_mag[%0d]: got %0d expected %0d+-6", r, io.x_out, VMAG);
      end
      checks++;
      if (io.y_out < -4 || io.y_out > 4) begin
        fails++; $display("[TB] FAIL vec_y[%0d]: got %0d expected 0+-4", r, io.y_out);
      end
      checks++;
      if (io.z_out < 8190 || io.z_out > 8194) begin
        fails++; $display("[TB] FAIL vec_angle[%0d]: got %0d expected 8192+-2", r, io.z_out);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit got;
    logic signed [17:0] cx, cy;
    logic signed [15:0] cz;
    send(1'b0, 10000, 0, 8192, 2'b01, lat, got);
    checks++;
    if (!got) begin
      fails++; $display("[TB] FAIL bp_first_valid: got %b expected 1", got);
    end
    cx = io.x_out; cy = io.y_out; cz = io.z_out;
    io.mode = 1'b1; io.x_in = 18'sd10000; io.y_in = 18'sd10000; io.z_in = 16'sd0;
    io.d_in = 2'b00; io.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 ||
          io.x_out !== cx || io.y_out !== cy || io.z_out !== cz) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b out=%0d/%0d/%0d expected 1/0 %0d/%0d/%0d",
                 c, io.out_valid, io.in_ready, io.x_out, io.y_out, io.z_out, cx, cy, cz);
      end
    end
    release_result();
    checks++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", io.out_valid, io.in_ready);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    checks++;
    if (io.busy !== 1'b1 || io.in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_next_accept: got busy=%b ready=%b expected 1/0", io.busy, io.in_ready);
    end
    lat = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = io.out_valid;
    end
    checks++;
    if (!got || lat != LAT16) begin
      fails++; $display("[TB] FAIL bp_second_latency: got %0d (valid=%b) expected %0d", lat, got, LAT16);
    end
    checks++;
    if (io.z_out < 8190 || io.z_out > 8194 || io.x_out < VMAG - 6 || io.x_out > VMAG + 6) begin
      fails++; $display("[TB] FAIL bp_second_result: got x=%0d z=%0d expected %0d+-6 8192+-2", io.x_out, io.z_out, VMAG);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    bit rose;
    @(negedge clk);
    io.mode = 1'b0; io.x_in = 18'sd10000; io.y_in = 18'sd0; io.z_in = 16'sd8192;
    io.d_in = 2'b01; io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (io.in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL midrun_in_ready: got %b expected 0", io.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (io.busy !== 1'b0 || io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midrun_flags: got busy=%b valid=%b ready=%b expected 0/0/1", io.busy, io.out_valid, io.in_ready);
    end
    checks++;
    if (io.x_out !== 18'sd0 || io.y_out !== 18'sd0 || io.z_out !== 16'sd0) begin
      fails++; $display("[TB] FAIL midrun_outputs: got %0d/%0d/%0d expected 0/0/0", io.x_out, io.y_out, io.z_out);
    end
    rose = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (io.out_valid === 1'b1) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      fails++; $display("[TB] FAIL midrun_no_output: got out_valid rise=1 expected 0");
    end
  endtask

  task automatic test_iter1();
    int lat; bit got;
    @(negedge clk);
    io1.mode = 1'b0; io1.x_in = 18'sd1000; io1.y_in = 18'sd0; io1.z_in = 16'sd100;
    io1.d_in = 2'b01; io1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io1.in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      got = io1.out_valid;
    end
    checks++;
    if (!got || lat != LAT1) begin
      fails++; $display("[TB] FAIL iter1_latency: got %0d (valid=%b) expected %0d", lat, got, LAT1);
    end
    checks++;
    if (io1.x_out != IT1_XY || io1.y_out != IT1_XY) begin
      fails++; $display("[TB] FAIL iter1_xy: got %0d/%0d expected %0d/%0d", io1.x_out, io1.y_out, IT1_XY, IT1_XY);
    end
    checks++;
    if (io1.z_out !== -16'sd8092) begin
      fails++; $display("[TB] FAIL iter1_z: got %0d expected -8092", io1.z_out);
    end
    io1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io1.out_ready = 1'b0;
    checks++;
    if (io1.out_valid !== 1'b0 || io1.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL iter1_release: got valid=%b ready=%b expected 0/1", io1.out_valid, io1.in_ready);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    io.in_valid = 1'b0; io.mode = 1'b0; io.x_in = '0; io.y_in = '0; io.z_in = '0;
    io.d_in = '0; io.out_ready = 1'b0;
    io1.in_valid = 1'b0; io1.mode = 1'b0; io1.x_in = '0; io1.y_in = '0; io1.z_in = '0;
    io1.d_in = '0; io1.out_ready = 1'b0;
    test_reset();
    test_rotation();
    test_rotation_neg();
    test_vector();
    test_back_to_back();
    test_reset_mid_run();
    test_iter1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
